// File: rtl/key_extract_cfg_if.sv
// Config-word handshake from the control-packet parser to the key-extract
// config sequencer.
interface key_extract_cfg_if #(
    parameter int STAGE_W = 3,
    parameter int KEY_OFF = 18
);
    logic [STAGE_W+KEY_OFF-1:0] cfg_data_in;
    logic                       cfg_valid_in;
    logic                       cfg_ready_out;

    modport master (output cfg_data_in, output cfg_valid_in, input  cfg_ready_out);
    modport slave  (input  cfg_data_in, input  cfg_valid_in, output cfg_ready_out);
endinterface

// File: rtl/key_extract_cfg_ctrl.sv
// Drains the pipeline before writing a new key offset into one key_extract
// stage, so no PHV ever sees a partially updated offset table.
module key_extract_cfg_ctrl #(
    parameter int NUM_STAGES = 5,
    parameter int KEY_OFF    = 18,
    parameter int STAGE_W    = 3,
    parameter int CNT_W      = 6,
    parameter int TIMEOUT    = 1023
) (
    input  logic                  clk,
    input  logic                  rst_n,
    key_extract_cfg_if.slave      cfg,
    input  logic                  phv_valid_entry,
    input  logic                  phv_valid_exit,
    output logic                  hold_out,
    output logic [KEY_OFF-1:0]    key_offset_out,
    output logic [NUM_STAGES-1:0] key_offset_valid_out,
    output logic                  cfg_done_out,
    output logic                  cfg_err_out
);
    localparam int TMO_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, DRAIN, APPLY, DONE} state_e;

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [TMO_W-1:0]        tmo_q, tmo_d;
    logic [STAGE_W-1:0]      stage_q, stage_d;
    logic [KEY_OFF-1:0]      off_q, off_d;
    logic [KEY_OFF-1:0]      koff_q, koff_d;
    logic [NUM_STAGES-1:0]   strb_q, strb_d;
    logic                    hold_q, hold_d;
    logic                    done_q, done_d;
    logic                    err_q, err_d;

    logic [STAGE_W-1:0]      cfg_id;
    logic [KEY_OFF-1:0]      cfg_off;

    assign cfg_id            = cfg.cfg_data_in[STAGE_W+KEY_OFF-1 -: STAGE_W];
    assign cfg_off           = cfg.cfg_data_in[KEY_OFF-1:0];
    assign cfg.cfg_ready_out = (state_q == IDLE);

    assign hold_out             = hold_q;
    assign key_offset_out       = koff_q;
    assign key_offset_valid_out = strb_q;
    assign cfg_done_out         = done_q;
    assign cfg_err_out          = err_q;

    // In-flight count runs in every state; saturating both ways.
    always_comb begin
        cnt_d = cnt_q;
        if (phv_valid_entry && !phv_valid_exit && cnt_q != {CNT_W{1'b1}})
            cnt_d = cnt_q + 1'b1;
        else if (phv_valid_exit && !phv_valid_entry && cnt_q != '0)
            cnt_d = cnt_q - 1'b1;
    end

    always_comb begin
        state_d = state_q;
        tmo_d   = tmo_q;
        stage_d = stage_q;
        off_d   = off_q;
        koff_d  = koff_q;
        strb_d  = '0;
        hold_d  = hold_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (cfg.cfg_valid_in) begin
                    if (32'(cfg_id) >= NUM_STAGES) begin
                        err_d = 1'b1;
                    end else begin
                        stage_d = cfg_id;
                        off_d   = cfg_off;
                        hold_d  = 1'b1;
                        tmo_d   = '0;
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // An entry this cycle is not yet in cnt_q, so it also blocks the write.
                if (cnt_q == '0 && !phv_valid_entry) begin
                    koff_d  = off_q;
                    strb_d  = NUM_STAGES'(1) << stage_q;
                    state_d = APPLY;
                end else if (tmo_q == TMO_W'(TIMEOUT)) begin
                    hold_d  = 1'b0;
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            APPLY: begin
                hold_d  = 1'b0;
                done_d  = 1'b1;
                state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            tmo_q   <= '0;
            stage_q <= '0;
            off_q   <= '0;
            koff_q  <= '0;
            strb_q  <= '0;
            hold_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
            stage_q <= stage_d;
            off_q   <= off_d;
            koff_q  <= koff_d;
            strb_q  <= strb_d;
            hold_q  <= hold_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end
endmodule

// File: tb/tb_key_extract_cfg_ctrl.sv
// Directed bench for key_extract_cfg_ctrl: latency, drain gating, bad id,
// drain timeout and mid-drain reset.
module tb_key_extract_cfg_ctrl;
    localparam int NUM_STAGES = 5;
    localparam int KEY_OFF    = 18;
    localparam int STAGE_W    = 3;

    logic clk = 1'b0;
    logic rst_n;
    logic phv_valid_entry, phv_valid_exit;
    logic hold_out, cfg_done_out, cfg_err_out;
    logic [KEY_OFF-1:0]    key_offset_out;
    logic [NUM_STAGES-1:0] key_offset_valid_out;

    int n_chk = 0;
    int n_err = 0;

    key_extract_cfg_if #(.STAGE_W(STAGE_W), .KEY_OFF(KEY_OFF)) cfg_if ();

    key_extract_cfg_ctrl #(
        .NUM_STAGES(NUM_STAGES), .KEY_OFF(KEY_OFF), .STAGE_W(STAGE_W),
        .CNT_W(6), .TIMEOUT(1023)
    ) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .cfg                  (cfg_if),
        .phv_valid_entry      (phv_valid_entry),
        .phv_valid_exit       (phv_valid_exit),
        .hold_out             (hold_out),
        .key_offset_out       (key_offset_out),
        .key_offset_valid_out (key_offset_valid_out),
        .cfg_done_out         (cfg_done_out),
        .cfg_err_out          (cfg_err_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one config word; returns 1 ns after the accepting edge (E0).
    task automatic send(input logic [STAGE_W-1:0] id, input logic [KEY_OFF-1:0] off);
        cfg_if.cfg_data_in  = {id, off};
        cfg_if.cfg_valid_in = 1'b1;
        step();
        cfg_if.cfg_valid_in = 1'b0;
    endtask

    task automatic chk_outs(input string tag, input logic [4:0] strb, input logic hold,
                            input logic done, input logic err, input logic rdy);
        chk({tag, "_strb"}, 32'(key_offset_valid_out), 32'(strb));
        chk({tag, "_hold"}, 32'(hold_out), 32'(hold));
        chk({tag, "_done"}, 32'(cfg_done_out), 32'(done));
        chk({tag, "_err"},  32'(cfg_err_out), 32'(err));
        chk({tag, "_rdy"},  32'(cfg_if.cfg_ready_out), 32'(rdy));
    endtask

    logic bad;

    initial begin
        rst_n = 1'b0;
        phv_valid_entry = 1'b0;
        phv_valid_exit  = 1'b0;
        cfg_if.cfg_data_in  = '0;
        cfg_if.cfg_valid_in = 1'b0;
        #12;
        chk_outs("rst", 5'b0, 0, 0, 0, 1);
        chk("rst_koff", 32'(key_offset_out), 32'h0);
        rst_n = 1'b1;
        step();

        // Empty pipeline: strobe after E1, done after E2, ready after E3.
        send(3'd2, 18'h0A5C3);
        chk_outs("t1_e0", 5'b00000, 1, 0, 0, 0);
        step();
        chk_outs("t1_e1", 5'b00100, 1, 0, 0, 0);
        chk("t1_koff", 32'(key_offset_out), 32'h0A5C3);
        step();
        chk_outs("t1_e2", 5'b00000, 0, 1, 0, 0);
        step();
        chk_outs("t1_e3", 5'b00000, 0, 0, 0, 1);
        chk("t1_koff_hold", 32'(key_offset_out), 32'h0A5C3);

        // Three PHVs in flight, exits spaced apart.
        phv_valid_entry = 1'b1;
        repeat (3) step();
        phv_valid_entry = 1'b0;
        send(3'd0, 18'h3FFFF);
        for (int k = 0; k < 3; k++) begin
            phv_valid_exit = 1'b1;
            step();
            phv_valid_exit = 1'b0;
            chk("t2_no_early", 32'(key_offset_valid_out), 32'h0);
            if (k < 2) begin
                step();
                chk("t2_no_early2", 32'(key_offset_valid_out), 32'h0);
            end
        end
        step();
        chk_outs("t2_apply", 5'b00001, 1, 0, 0, 0);
        chk("t2_koff", 32'(key_offset_out), 32'h3FFFF);
        step();
        chk_outs("t2_done", 5'b00000, 0, 1, 0, 0);
        step();

        // Entry as hold rises, then simultaneous entry/exit keeps the count at 1.
        send(3'd4, 18'h12345);
        phv_valid_entry = 1'b1;
        step();
        chk("t3_entry_blk", 32'(key_offset_valid_out), 32'h0);
        phv_valid_exit = 1'b1;
        repeat (3) begin
            step();
            chk("t3_simul", 32'(key_offset_valid_out), 32'h0);
        end
        phv_valid_entry = 1'b0;
        step();
        chk("t3_last_exit", 32'(key_offset_valid_out), 32'h0);
        phv_valid_exit = 1'b0;
        step();
        chk_outs("t3_apply", 5'b10000, 1, 0, 0, 0);
        chk("t3_koff", 32'(key_offset_out), 32'h12345);
        step();
        chk_outs("t3_done", 5'b00000, 0, 1, 0, 0);
        step();

        // Out-of-range stage id.
        send(3'd6, 18'h01111);
        chk_outs("t4_err", 5'b00000, 0, 0, 1, 1);
        step();
        chk_outs("t4_after", 5'b00000, 0, 0, 0, 1);
        chk("t4_koff", 32'(key_offset_out), 32'h12345);

        // Drain timeout: one PHV never leaves.
        phv_valid_entry = 1'b1;
        step();
        phv_valid_entry = 1'b0;
        send(3'd1, 18'h00ABC);
        bad = 1'b0;
        for (int i = 1; i <= 1023; i++) begin
            step();
            if (key_offset_valid_out != 0 || cfg_err_out || !hold_out || cfg_done_out) bad = 1'b1;
        end
        chk("t5_wait", 32'(bad), 32'h0);
        step();
        chk_outs("t5_expire", 5'b00000, 0, 0, 1, 1);
        chk("t5_koff", 32'(key_offset_out), 32'h12345);
        step();
        chk("t5_err_once", 32'(cfg_err_out), 32'h0);
        phv_valid_exit = 1'b1;
        step();
        phv_valid_exit = 1'b0;

        // Reset in the middle of a drain.
        phv_valid_entry = 1'b1;
        step();
        phv_valid_entry = 1'b0;
        send(3'd3, 18'h2AAAA);
        step();
        step();
        rst_n = 1'b0;
        #1;
        chk_outs("t6_rst", 5'b00000, 0, 0, 0, 1);
        chk("t6_koff", 32'(key_offset_out), 32'h0);
        step();
        rst_n = 1'b1;
        step();
        chk_outs("t6_idle", 5'b00000, 0, 0, 0, 1);
        send(3'd1, 18'h00777);
        step();
        chk_outs("t6_apply", 5'b00010, 1, 0, 0, 0);
        chk("t6_koff2", 32'(key_offset_out), 32'h00777);
        step();
        chk_outs("t6_done", 5'b00000, 0, 1, 0, 0);
        step();
        chk_outs("t6_end", 5'b00000, 0, 0, 0, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
